// File: rtl/dct_transpose_buffer.sv
// Transpose buffer between the row-pass and column-pass 1-D DCTs of an 8x8
// 2-D DCT. It takes coefficients row-major and re-emits each 64-sample block
// column-major. Two ping-pong banks let one block fill while the other drains.
module dct_transpose_buffer #(
  parameter int bits = 25
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] in,
  input  logic            in_valid,
  input  logic            in_row_start,
  output logic [bits-1:0] O,
  output logic            out_valid,
  output logic            out_col_start,
  output logic            out_blk_start,
  output logic            sync_err
);

  typedef enum logic {W_SYNC, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

  // Both banks share one array. The address is {bank, row[2:0], col[2:0]}.
  logic [bits-1:0] mem [128];

  wstate_t    w_st, w_nx;
  logic [2:0] wr_row, row_nx;
  logic [2:0] wr_col, col_nx;
  logic       wr_bank, bank_nx;
  logic       we;
  logic [6:0] waddr;
  logic       set_pend, set_err;

  rstate_t    r_st, r_nx;
  logic [5:0] k, k_nx;
  logic       rd_bank, rbank_nx;
  logic       rd_en, clr_pend;
  logic [5:0] rk;
  logic       rb;
  logic [6:0] raddr;

  logic       pending, pend_nx;

  // Writer next state. It walks row-major through the fill bank and resyncs
  // to column 0 when a row start arrives early.
  always_comb begin
    w_nx     = w_st;
    row_nx   = wr_row;
    col_nx   = wr_col;
    bank_nx  = wr_bank;
    we       = 1'b0;
    waddr    = {wr_bank, wr_row, wr_col};
    set_pend = 1'b0;
    set_err  = 1'b0;
    case (w_st)
      W_SYNC: begin
        if (in_valid && in_row_start) begin
          we     = 1'b1;
          waddr  = {wr_bank, 3'd0, 3'd0};
          row_nx = 3'd0;
          col_nx = 3'd1;
          w_nx   = W_FILL;
        end
      end
      W_FILL: begin
        if (in_valid) begin
          we = 1'b1;
          if (in_row_start && (wr_col != 3'd0)) begin
            // Early row start: restart the current row and overwrite the
            // partial data.
            waddr   = {wr_bank, wr_row, 3'd0};
            col_nx  = 3'd1;
            set_err = 1'b1;
          end else if (wr_col == 3'd7) begin
            col_nx = 3'd0;
            if (wr_row == 3'd7) begin
              row_nx   = 3'd0;
              bank_nx  = ~wr_bank;
              set_pend = 1'b1;
            end else begin
              row_nx = wr_row + 3'd1;
            end
          end else begin
            col_nx = wr_col + 3'd1;
          end
        end
      end
      default: w_nx = W_SYNC;
    endcase
  end

  // Reader next state. A pending block is emitted on the same edge it is
  // picked up, so the latency is one cycle. Returning to R_IDLE after k=63
  // costs no cycle, because R_IDLE emits at once when a block is pending.
  always_comb begin
    r_nx     = r_st;
    k_nx     = k;
    rbank_nx = rd_bank;
    rd_en    = 1'b0;
    clr_pend = 1'b0;
    rk       = k;
    rb       = rd_bank;
    case (r_st)
      R_IDLE: begin
        if (pending) begin
          rd_en    = 1'b1;
          clr_pend = 1'b1;
          rk       = 6'd0;
          rb       = ~wr_bank;   // the bank that was just completed
          rbank_nx = ~wr_bank;
          k_nx     = 6'd1;
          r_nx     = R_DRAIN;
        end
      end
      R_DRAIN: begin
        rd_en = 1'b1;
        if (k == 6'd63) begin
          k_nx = 6'd0;
          r_nx = R_IDLE;
        end else begin
          k_nx = k + 6'd1;
        end
      end
      default: r_nx = R_IDLE;
    endcase
  end

  // Column-major read: k[2:0] selects the row and k[5:3] selects the column.
  assign raddr   = {rb, rk[2:0], rk[5:3]};
  // A set and a clear never land on the same edge. If they did, the set
  // would win.
  assign pend_nx = set_pend | (pending & ~clr_pend);

  // Bank storage is written only. It is never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= in;
  end

  // State registers and the registered output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_st          <= W_SYNC;
      wr_row        <= 3'd0;
      wr_col        <= 3'd0;
      wr_bank       <= 1'b0;
      pending       <= 1'b0;
      r_st          <= R_IDLE;
      k             <= 6'd0;
      rd_bank       <= 1'b0;
      O             <= '0;
      out_valid     <= 1'b0;
      out_col_start <= 1'b0;
      out_blk_start <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      w_st          <= w_nx;
      wr_row        <= row_nx;
      wr_col        <= col_nx;
      wr_bank       <= bank_nx;
      pending       <= pend_nx;
      r_st          <= r_nx;
      k             <= k_nx;
      rd_bank       <= rbank_nx;
      if (rd_en) O  <= mem[raddr];
      out_valid     <= rd_en;
      out_col_start <= rd_en && (rk[2:0] == 3'd0);
      out_blk_start <= rd_en && (rk == 6'd0);
      sync_err      <= sync_err | set_err;
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Bench for dct_transpose_buffer. A block-level model collects each 8x8
// block as an array. When a block completes, the model queues the 64
// transposed outputs with the cycle each one should appear on. A monitor
// compares every cycle against that queue.
module tb_dct_transpose_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [24:0] din = '0;
  logic        in_valid = 1'b0;
  logic        in_row_start = 1'b0;
  logic [24:0] O;
  logic        out_valid, out_col_start, out_blk_start, sync_err;

  int n_cmp = 0;
  int n_err = 0;
  int ecnt  = 0;   // number of rising edges seen so far

  typedef struct {
    int          e;
    logic [24:0] v;
    logic        cs;
    logic        bs;
  } exp_t;
  exp_t q[$];

  // Reference model state: the block being filled, the position in it, and
  // the edge from which sync_err is expected high.
  logic [24:0] mb [64];
  bit          m_sync = 0;
  int          m_row = 0, m_col = 0;
  int          m_err_edge = 1 << 30;

  dct_transpose_buffer #(.bits(25)) dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid),
    .in_row_start(in_row_start), .O(O), .out_valid(out_valid),
    .out_col_start(out_col_start), .out_blk_start(out_blk_start),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // A finished block drains transposed. Output j comes from row j%8 and
  // column j/8, on edge e+1+j.
  task automatic push_block(input int e);
    for (int j = 0; j < 64; j++)
      q.push_back('{e + 1 + j, mb[(j % 8) * 8 + j / 8], (j % 8) == 0, j == 0});
  endtask

  task automatic model_accept(input logic [24:0] v, input logic rs, input int e);
    if (!m_sync) begin
      if (rs) begin
        m_sync = 1; mb[0] = v; m_row = 0; m_col = 1;
      end
    end else if (rs && m_col != 0) begin
      if (m_err_edge > e) m_err_edge = e;
      mb[m_row * 8] = v; m_col = 1;
    end else begin
      mb[m_row * 8 + m_col] = v;
      if (m_col == 7) begin
        m_col = 0;
        if (m_row == 7) begin m_row = 0; push_block(e); end
        else m_row++;
      end else m_col++;
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_row = 0; m_col = 0; m_err_edge = 1 << 30;
    q.delete();
  endtask

  // Presents one input cycle. The next rising edge captures it.
  task automatic drive(input logic [24:0] v, input logic rs, input logic vld);
    @(posedge clk); #1;
    din = v; in_valid = vld; in_row_start = rs;
    if (vld) model_accept(v, rs, ecnt + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0);
  endtask

  // Per-cycle output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (q.size() > 0 && q[0].e == ecnt) begin
        chk("valid", 32'(out_valid), 32'(1));
        chk("data", 32'(O), 32'(q[0].v));
        chk("col_start", 32'(out_col_start), 32'(q[0].cs));
        chk("blk_start", 32'(out_blk_start), 32'(q[0].bs));
        void'(q.pop_front());
      end else begin
        chk("idle_valid", 32'(out_valid), 32'(0));
        chk("idle_col_start", 32'(out_col_start), 32'(0));
        chk("idle_blk_start", 32'(out_blk_start), 32'(0));
      end
      chk("sync_err", 32'(sync_err), 32'(ecnt >= m_err_edge));
      if (dut.set_pend) chk("pend_overlap", 32'(dut.pending), 32'(0));
    end
  end

  initial begin
    int e_last;
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_O", 32'(O), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_col_start", 32'(out_col_start), 32'(0));
    chk("rst_blk_start", 32'(out_blk_start), 32'(0));
    chk("rst_sync_err", 32'(sync_err), 32'(0));
    @(posedge clk); #1; rst = 1'b1;

    // Before the first row start, samples must be ignored.
    for (int i = 0; i < 5; i++) drive(25'($urandom), 1'b0, 1'b1);

    // Ramp block.
    for (int i = 0; i < 64; i++) drive(25'(i), i % 8 == 0, 1'b1);
    idle(70);

    // Back-to-back blocks.
    for (int i = 0; i < 64; i++) drive(25'(i), i % 8 == 0, 1'b1);
    for (int i = 0; i < 64; i++) drive(25'(100 + i), i % 8 == 0, 1'b1);
    idle(70);

    // The input stalls every third cycle.
    for (int i = 0, c = 0; i < 64; c++) begin
      if (c % 3 == 2) idle(1);
      else begin drive(25'(i), i % 8 == 0, 1'b1); i++; end
    end
    idle(70);

    // Random data with random stalls, three blocks in a row.
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        drive(25'($urandom), i % 8 == 0, 1'b1);
      end
    idle(70);

    // Signed extremes, back to back.
    for (int i = 0; i < 64; i++) drive(25'h1FFFFFF, i % 8 == 0, 1'b1);
    for (int i = 0; i < 64; i++) drive(25'h1000000, i % 8 == 0, 1'b1);
    idle(70);

    // Resync: an early row start in row 2 restarts that row with value 77.
    for (int i = 0; i < 16; i++) drive(25'($urandom), i % 8 == 0, 1'b1);
    for (int i = 0; i < 5; i++) drive(25'($urandom), i == 0, 1'b1);
    drive(25'd77, 1'b1, 1'b1);
    for (int i = 1; i < 8; i++) drive(25'($urandom), 1'b0, 1'b1);
    for (int i = 24; i < 64; i++) drive(25'($urandom), i % 8 == 0, 1'b1);
    idle(70);

    // Reset while output k=20 of a random block is being shown.
    for (int i = 0; i < 64; i++) drive(25'($urandom_range(1, 1 << 24)), i % 8 == 0, 1'b1);
    e_last = ecnt + 1;
    while (ecnt < e_last + 21) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_O", 32'(O), 32'(0));
    chk("mid_rst_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_blk_start", 32'(out_blk_start), 32'(0));
    chk("mid_rst_sync_err", 32'(sync_err), 32'(0));
    model_reset();
    @(posedge clk); #1; rst = 1'b1;

    // Samples without a row start must not produce any output.
    for (int i = 0; i < 10; i++) drive(25'($urandom), 1'b0, 1'b1);
    idle(80);
    for (int i = 0; i < 64; i++) drive(25'($urandom), i % 8 == 0, 1'b1);
    idle(70);
    chk("drain_done", 32'(q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dct_transpose_buffer.md
Name: dct_transpose_buffer

Overview:
- Transposition stage between the row-pass 1-D DCT and the column-pass 1-D DCT of the 8x8 2-D DCT pipeline.
- Accepts 25-bit coefficients row-major: 8 rows of 8, one coefficient per cycle.
- Re-emits each 64-coefficient block column-major as a continuous 1-sample/cycle stream for the column DCT.
- Ping-pong double buffering lets one block fill while the previous block drains, so streaming has no gaps.

Parameters:
- bits, 25, coefficient width (two's complement), passed through unmodified.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in  input  bits  row-DCT coefficient.
- in_valid  input  1  `in` is valid this cycle.
- in_row_start  input  1  with in_valid, marks coefficient 0 of a row; driven by the row DCT's finish_computing.
- O  output  bits  transposed coefficient.
- out_valid  output  1  O is valid.
- out_col_start  output  1  O is element 0 of a column.
- out_blk_start  output  1  O is element 0 of a block.
- sync_err  output  1  sticky flag: row-start misalignment was detected.

Behaviour:
- Storage: two banks, 64 x bits each, addressed {row[2:0], col[2:0]}. Bank contents are not reset.
- Reset (rst=0, asynchronous), all outputs and state cleared:
  - O=0, out_valid=0, out_col_start=0, out_blk_start=0, sync_err=0.
  - Writer in W_SYNC, reader in R_IDLE, wr_bank=0, pending=0, all counters 0.
  - Reset mid-block discards both partial and complete-but-undrained blocks.
- Writer FSM:
  - W_SYNC: ignores data until in_valid & in_row_start. That sample is written to wr_bank[row0][col0]; then col=1, and the writer goes to W_FILL.
  - W_FILL: each in_valid sample is written to wr_bank[row][col], then col increments.
  - At col 7, col wraps to 0 and row increments.
  - On the write of row7/col7: wr_bank toggles, pending=1, row=0.
  - Cycles with in_valid=0 hold all writer state.
- Resync rule: in_valid & in_row_start while col!=0 in W_FILL:
  - sync_err is set.
  - The sample is written as col 0 of the current row index; the partial row is overwritten.
  - Then col=1; row is unchanged.
- in_row_start at col 0 is the expected case and has no effect beyond the normal write.
- Reader FSM:
  - R_IDLE: if pending, it clears pending, latches rd_bank = the just-completed bank, sets k=0, and enters R_DRAIN.
  - R_DRAIN: one output per cycle, k = 0..63.
    - Read address: row=k[2:0], col=k[5:3].
    - out_col_start = (k[2:0]==0); out_blk_start = (k==0).
  - After k=63: if pending is set, start the next block with no idle cycle; otherwise return to R_IDLE.
- Output timing:
  - O, out_valid and the start flags are registered.
  - The last write of a block at edge E gives the first output at edge E+1 and the last output at edge E+64.
  - Latency from the block's last input to its first output is 1 cycle.
- Outputs in idle: out_valid=0 and both start flags 0; O holds its last value.
- Bank collision:
  - Input rate is at most 1/cycle, so the writer needs at least 64 cycles per bank while the reader needs exactly 64.
  - The writer therefore never overwrites a bank still draining, and pending is never set while already set. A bench assertion checks this.
- Same-edge write and read: the last write of block n+1 and the last read of block n may fall on the same edge. This hands over seamlessly.
- Arithmetic: none; data is bit-exact, with sign preserved.

Test Plan:
- Ramp: one block with in = 0..63 row-major, row_start every 8th sample -> out_valid for 64 cycles starting 1 cycle after the last input. O = 0,8,16,...,56,1,9,...,63. out_col_start at outputs 0,8,...,56; out_blk_start only at output 0.
- Back-to-back: blocks with values 0..63 then 100..163, continuous -> 128 contiguous valid outputs with no gap. The second block's output starts at 100,108,...; sync_err stays 0.
- Gaps: block 0..63 with in_valid deasserted every 3rd cycle -> same output order. Output begins 1 cycle after the 64th accepted sample.
- Resync: after 5 samples of row 2, assert in_row_start with value 77 -> sync_err=1 (sticky). 77 lands at [2][0]. The block completes after 8 further samples of row 2 plus rows 3..7.
- Signed pass-through: all samples = 25'h1FFFFFF (-1) or 25'h1000000 -> identical values on O.
- Reset mid-drain: drive rst=0 at output k=20 -> O=0 and out_valid=0 immediately (async). After release, nothing is output until a new in_row_start-aligned 64-sample block arrives.
